// File: rtl/pong_pkg.sv
// Shared constants for the pong input path: button indices, default debounce
// length and the per-button debounce state encoding.
package pong_pkg;

  localparam int unsigned BTN_U = 0;
  localparam int unsigned BTN_D = 1;
  localparam int unsigned BTN_L = 2;
  localparam int unsigned BTN_R = 3;

  // 10 ms at the 12.5 MHz DIV_CLK[1] clock
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 125000;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } db_state_t;

endpackage

// File: rtl/btn_conditioner_if.sv
// Button conditioner signal bundle: raw buttons and frame sync in, clean
// levels, edge pulses and per-frame requests out.
interface btn_conditioner_if #(
  parameter int unsigned NUM_BTNS = 4
);

  logic [NUM_BTNS-1:0] btn_raw;
  logic                frame_sync;
  logic [NUM_BTNS-1:0] btn_level;
  logic [NUM_BTNS-1:0] btn_press;
  logic [NUM_BTNS-1:0] btn_release;
  logic                frame_tick;
  logic [NUM_BTNS-1:0] frame_req;

  modport master (
    output btn_raw, frame_sync,
    input  btn_level, btn_press, btn_release, frame_tick, frame_req
  );

  modport slave (
    input  btn_raw, frame_sync,
    output btn_level, btn_press, btn_release, frame_tick, frame_req
  );

endinterface

// File: rtl/btn_debounce.sv
// One-bit synchronizer + debounce FSM with level/press/release outputs.
// Define AUTOREPEAT_EN to emit repeated press pulses while a button is held.
module btn_debounce
  import pong_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = 5000000,
  parameter int unsigned REPEAT_PERIOD   = 1250000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release
);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_cfg_check
    $error("btn_debounce: need DEBOUNCE_CYCLES >= 2 and 1 <= REPEAT_PERIOD <= REPEAT_DELAY");
  end

  localparam int unsigned       CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_q1;
  logic             sync_q2;
  db_state_t        state;
  db_state_t        state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] cnt_inc;
  logic             level_d;
  logic             rpt_fire;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      state   <= STABLE_LO;
      cnt     <= '0;
      level_d <= 1'b0;
    end else begin
      sync_q1 <= btn_raw;
      sync_q2 <= sync_q1;
      state   <= state_next;
      cnt     <= cnt_next;
      level_d <= btn_level;
    end
  end

  // The sample that moves STABLE_x into WAIT_y is the first stable sample, so the
  // flip happens once the saturating count reaches DEBOUNCE_CYCLES-1 further samples.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    cnt_inc    = (cnt == CNT_LAST) ? cnt : cnt + 1'b1;
    unique case (state)
      STABLE_LO: if (sync_q2) begin
        state_next = WAIT_HI;
        cnt_next   = '0;
      end
      WAIT_HI: if (!sync_q2) begin
        state_next = STABLE_LO;
        cnt_next   = '0;
      end else if (cnt_inc == CNT_LAST) begin
        state_next = STABLE_HI;
        cnt_next   = '0;
      end else begin
        cnt_next = cnt_inc;
      end
      STABLE_HI: if (!sync_q2) begin
        state_next = WAIT_LO;
        cnt_next   = '0;
      end
      WAIT_LO: if (sync_q2) begin
        state_next = STABLE_HI;
        cnt_next   = '0;
      end else if (cnt_inc == CNT_LAST) begin
        state_next = STABLE_LO;
        cnt_next   = '0;
      end else begin
        cnt_next = cnt_inc;
      end
      default: begin
        state_next = STABLE_LO;
        cnt_next   = '0;
      end
    endcase
  end

  always_comb begin
    btn_level   = (state == STABLE_HI) || (state == WAIT_LO);
    btn_press   = (btn_level & ~level_d) | rpt_fire;
    btn_release = ~btn_level & level_d;
  end

`ifdef AUTOREPEAT_EN
  localparam int unsigned      RPT_W      = $clog2(REPEAT_DELAY + 1);
  localparam logic [RPT_W-1:0] RPT_FIRST  = RPT_W'(REPEAT_DELAY);
  localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(REPEAT_DELAY - REPEAT_PERIOD);

  logic [RPT_W-1:0] rpt_cnt;
  logic [RPT_W-1:0] rpt_inc;

  assign rpt_inc = rpt_cnt + 1'b1;

  // Reloading to DELAY-PERIOD makes every later pulse land PERIOD cycles apart.
  always_ff @(posedge clk) begin
    if (!reset_n || state != STABLE_HI || state_next != STABLE_HI) begin
      rpt_cnt  <= '0;
      rpt_fire <= 1'b0;
    end else if (rpt_inc == RPT_FIRST) begin
      rpt_cnt  <= RPT_RELOAD;
      rpt_fire <= 1'b1;
    end else begin
      rpt_cnt  <= rpt_inc;
      rpt_fire <= 1'b0;
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

endmodule

// File: rtl/btn_conditioner.sv
// Debounces the board buttons and latches a per-frame move request on each
// falling edge of vga_v_sync. Define AUTOREPEAT_EN for held-button repeat presses.
module btn_conditioner
  import pong_pkg::*;
#(
  parameter int unsigned NUM_BTNS        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = 5000000,
  parameter int unsigned REPEAT_PERIOD   = 1250000
) (
  input logic               clk,
  input logic               reset_n,
  btn_conditioner_if.slave  bus
);

  logic [NUM_BTNS-1:0] level;
  logic [NUM_BTNS-1:0] press;
  logic [NUM_BTNS-1:0] rel;
  logic [NUM_BTNS-1:0] pending;
  logic [NUM_BTNS-1:0] frame_req;
  logic                prev_sync;
  logic                frame_tick;

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_debounce (
      .clk         (clk),
      .reset_n     (reset_n),
      .btn_raw     (bus.btn_raw[i]),
      .btn_level   (level[i]),
      .btn_press   (press[i]),
      .btn_release (rel[i])
    );
  end

  // A press coinciding with the tick goes straight into the new request and is
  // kept out of pending, so it is never counted in two frames.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prev_sync  <= 1'b1;
      frame_tick <= 1'b0;
      pending    <= '0;
      frame_req  <= '0;
    end else begin
      prev_sync  <= bus.frame_sync;
      frame_tick <= prev_sync & ~bus.frame_sync;
      if (frame_tick) begin
        frame_req <= level | pending | press;
        pending   <= '0;
      end else begin
        pending <= pending | press;
      end
    end
  end

  assign bus.btn_level   = level;
  assign bus.btn_press   = press;
  assign bus.btn_release = rel;
  assign bus.frame_tick  = frame_tick;
  assign bus.frame_req   = frame_req;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=20,
// REPEAT_PERIOD=8; expected timings are hand-derived cycle counts.
module tb_btn_conditioner;
  import pong_pkg::*;

  logic clk;
  logic reset_n;
  int   n_checks = 0;
  int   n_pass   = 0;

  btn_conditioner_if #(.NUM_BTNS(4)) bus ();

  btn_conditioner #(
    .NUM_BTNS        (4),
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (20),
    .REPEAT_PERIOD   (8)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    reset_n        = 1'b0;
    bus.btn_raw    = '0;
    bus.frame_sync = 1'b1;
    tick(3);
    n_checks++; if (bus.btn_level !== 4'b0000) $display("FAIL reset_level: got %b, expected 0000", bus.btn_level); else n_pass++;
    n_checks++; if (bus.btn_press !== 4'b0000) $display("FAIL reset_press: got %b, expected 0000", bus.btn_press); else n_pass++;
    n_checks++; if (bus.btn_release !== 4'b0000) $display("FAIL reset_release: got %b, expected 0000", bus.btn_release); else n_pass++;
    n_checks++; if (bus.frame_tick !== 1'b0) $display("FAIL reset_tick: got %b, expected 0", bus.frame_tick); else n_pass++;
    n_checks++; if (bus.frame_req !== 4'b0000) $display("FAIL reset_req: got %b, expected 0000", bus.frame_req); else n_pass++;
    reset_n = 1'b1;
    tick(2);
  endtask

  task automatic test_clean_press;
    logic exp;
    bus.btn_raw[BTN_U] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      exp = (k == 6);
      n_checks++; if (bus.btn_press[BTN_U] !== exp) $display("FAIL press_pulse k=%0d: got %b, expected %b", k, bus.btn_press[BTN_U], exp); else n_pass++;
      exp = (k >= 6);
      n_checks++; if (bus.btn_level[BTN_U] !== exp) $display("FAIL press_level k=%0d: got %b, expected %b", k, bus.btn_level[BTN_U], exp); else n_pass++;
    end
    bus.btn_raw[BTN_U] = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      exp = (k == 6);
      n_checks++; if (bus.btn_release[BTN_U] !== exp) $display("FAIL release_pulse k=%0d: got %b, expected %b", k, bus.btn_release[BTN_U], exp); else n_pass++;
      exp = (k < 6);
      n_checks++; if (bus.btn_level[BTN_U] !== exp) $display("FAIL release_level k=%0d: got %b, expected %b", k, bus.btn_level[BTN_U], exp); else n_pass++;
    end
  endtask

  task automatic test_bounce;
    logic [7:0] pat;
    logic       exp;
    pat = 8'b0011_0011;
    for (int i = 0; i < 8; i++) begin
      bus.btn_raw[BTN_D] = pat[i];
      tick(1);
      n_checks++;
      if ({bus.btn_level[BTN_D], bus.btn_press[BTN_D]} !== 2'b00)
        $display("FAIL bounce_quiet i=%0d: got level/press %b%b, expected 00", i, bus.btn_level[BTN_D], bus.btn_press[BTN_D]);
      else n_pass++;
    end
    bus.btn_raw[BTN_D] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      exp = (k == 6);
      n_checks++; if (bus.btn_press[BTN_D] !== exp) $display("FAIL bounce_press k=%0d: got %b, expected %b", k, bus.btn_press[BTN_D], exp); else n_pass++;
    end
    bus.btn_raw[BTN_D] = 1'b0;
    tick(8);
  endtask

  task automatic test_tap_between_frames;
    bus.frame_sync = 1'b0;
    tick(1);
    n_checks++; if (bus.frame_tick !== 1'b1) $display("FAIL flush_tick: got %b, expected 1", bus.frame_tick); else n_pass++;
    tick(1);
    n_checks++; if (bus.frame_tick !== 1'b0) $display("FAIL flush_tick_width: got %b, expected 0", bus.frame_tick); else n_pass++;
    n_checks++; if (bus.frame_req !== 4'b0011) $display("FAIL flush_req: got %b, expected 0011", bus.frame_req); else n_pass++;
    bus.frame_sync = 1'b1;
    tick(2);
    bus.btn_raw[BTN_L] = 1'b1;
    tick(8);
    bus.btn_raw[BTN_L] = 1'b0;
    tick(8);
    n_checks++; if (bus.btn_level[BTN_L] !== 1'b0) $display("FAIL tap_level: got %b, expected 0", bus.btn_level[BTN_L]); else n_pass++;
    n_checks++; if (bus.frame_req !== 4'b0011) $display("FAIL tap_req_hold: got %b, expected 0011", bus.frame_req); else n_pass++;
    bus.frame_sync = 1'b0;
    tick(2);
    n_checks++; if (bus.frame_req !== 4'b0100) $display("FAIL tap_req: got %b, expected 0100", bus.frame_req); else n_pass++;
    bus.frame_sync = 1'b1;
    tick(2);
    bus.frame_sync = 1'b0;
    tick(1);
    n_checks++; if (bus.frame_tick !== 1'b1) $display("FAIL tap_next_tick: got %b, expected 1", bus.frame_tick); else n_pass++;
    tick(1);
    n_checks++; if (bus.frame_req !== 4'b0000) $display("FAIL tap_next_req: got %b, expected 0000", bus.frame_req); else n_pass++;
    bus.frame_sync = 1'b1;
    tick(2);
  endtask

  task automatic test_coincidence;
    bus.btn_raw[BTN_R] = 1'b1;
    tick(5);
    bus.frame_sync = 1'b0;
    tick(1);
    n_checks++; if (bus.btn_press[BTN_R] !== 1'b1) $display("FAIL coin_press: got %b, expected 1", bus.btn_press[BTN_R]); else n_pass++;
    n_checks++; if (bus.frame_tick !== 1'b1) $display("FAIL coin_tick: got %b, expected 1", bus.frame_tick); else n_pass++;
    tick(1);
    n_checks++; if (bus.frame_req !== 4'b1000) $display("FAIL coin_req: got %b, expected 1000", bus.frame_req); else n_pass++;
    bus.frame_sync     = 1'b1;
    bus.btn_raw[BTN_R] = 1'b0;
    tick(8);
    n_checks++; if (bus.btn_level[BTN_R] !== 1'b0) $display("FAIL coin_release_level: got %b, expected 0", bus.btn_level[BTN_R]); else n_pass++;
    bus.frame_sync = 1'b0;
    tick(2);
    n_checks++; if (bus.frame_req !== 4'b0000) $display("FAIL coin_no_double: got %b, expected 0000", bus.frame_req); else n_pass++;
    bus.frame_sync = 1'b1;
    tick(2);
  endtask

  task automatic test_reset_mid_debounce;
    logic [3:0] exp;
    bus.btn_raw[BTN_L] = 1'b1;
    tick(8);
    bus.frame_sync = 1'b0;
    tick(2);
    n_checks++; if (bus.frame_req !== 4'b0100) $display("FAIL prereset_req: got %b, expected 0100", bus.frame_req); else n_pass++;
    bus.frame_sync = 1'b1;
    tick(2);
    bus.btn_raw[BTN_U] = 1'b1;
    tick(4);
    reset_n = 1'b0;
    tick(1);
    n_checks++; if (bus.btn_level !== 4'b0000) $display("FAIL midreset_level: got %b, expected 0000", bus.btn_level); else n_pass++;
    n_checks++; if (bus.btn_press !== 4'b0000) $display("FAIL midreset_press: got %b, expected 0000", bus.btn_press); else n_pass++;
    n_checks++; if (bus.frame_req !== 4'b0000) $display("FAIL midreset_req: got %b, expected 0000", bus.frame_req); else n_pass++;
    reset_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      exp = (k == 6) ? 4'b0101 : 4'b0000;
      n_checks++; if (bus.btn_press !== exp) $display("FAIL rearm_press k=%0d: got %b, expected %b", k, bus.btn_press, exp); else n_pass++;
      n_checks++; if (bus.frame_tick !== 1'b0) $display("FAIL rearm_no_tick k=%0d: got %b, expected 0", k, bus.frame_tick); else n_pass++;
    end
    bus.btn_raw = '0;
    tick(8);
  endtask

  task automatic test_autorepeat;
    logic exp;
    bus.btn_raw[BTN_U] = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      tick(1);
      exp = (k == 6);
`ifdef AUTOREPEAT_EN
      if (k >= 26 && ((k - 26) % 8) == 0) exp = 1'b1;
`endif
      n_checks++; if (bus.btn_press[BTN_U] !== exp) $display("FAIL hold_press k=%0d: got %b, expected %b", k, bus.btn_press[BTN_U], exp); else n_pass++;
    end
    bus.btn_raw[BTN_U] = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      exp = (k == 6);
      n_checks++; if (bus.btn_release[BTN_U] !== exp) $display("FAIL hold_release k=%0d: got %b, expected %b", k, bus.btn_release[BTN_U], exp); else n_pass++;
      n_checks++; if (bus.btn_press[BTN_U] !== 1'b0) $display("FAIL hold_release_press k=%0d: got %b, expected 0", k, bus.btn_press[BTN_U]); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_tap_between_frames();
    test_coincidence();
    test_reset_mid_debounce();
    test_autorepeat();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

endmodule
